// File: rtl/morse_sequencer.sv
// Morse sequencer: accepts one ASCII character per valid/ready handshake and
// keys it out as ITU Morse on key_o, using one unit = CLK_DIV clock cycles.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | ready for a character, key off
// S_MARK     | key on for one element (1 unit dot, 3 units dash)
// S_ELEM_GAP | key off 1 unit between elements of one character
// S_CHAR_GAP | key off 3 units after the last element of a character
// S_WORD_GAP | key off 4 units for a space (7 total with the char gap)
module morse_sequencer #(
  parameter int CLK_DIV   = 12000,
  parameter int DIV_WIDTH = 16
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       char_valid_i,
  input  logic [7:0] char_i,
  output logic       char_ready_o,
  output logic       key_o,
  output logic       busy_o,
  output logic       error_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_ELEM_GAP,
    S_CHAR_GAP,
    S_WORD_GAP
  } state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_MAX = DIV_WIDTH'(CLK_DIV - 1);

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic [1:0]           unit_q, unit_d;
  logic [2:0]           idx_q, idx_d;
  logic [2:0]           len_q, len_d;
  logic [4:0]           pat_q, pat_d;
  logic                 key_q, key_d;
  logic                 err_q, err_d;

  logic [7:0] up_c;
  logic       dec_ok;
  logic       dec_space;
  logic [2:0] dec_len;
  logic [4:0] dec_pat;

  logic       transfer;
  logic       done;
  logic       load;
  logic [2:0] load_units;

  // Character decode: pattern is left-aligned, first element in bit 4, 1 = dash.
  always_comb begin
    up_c      = ((char_i >= 8'h61) && (char_i <= 8'h7a)) ? (char_i - 8'h20) : char_i;
    dec_ok    = 1'b1;
    dec_space = 1'b0;
    dec_len   = 3'd0;
    dec_pat   = 5'b00000;
    case (up_c)
      "A": {dec_len, dec_pat} = {3'd2, 5'b01000};
      "B": {dec_len, dec_pat} = {3'd4, 5'b10000};
      "C": {dec_len, dec_pat} = {3'd4, 5'b10100};
      "D": {dec_len, dec_pat} = {3'd3, 5'b10000};
      "E": {dec_len, dec_pat} = {3'd1, 5'b00000};
      "F": {dec_len, dec_pat} = {3'd4, 5'b00100};
      "G": {dec_len, dec_pat} = {3'd3, 5'b11000};
      "H": {dec_len, dec_pat} = {3'd4, 5'b00000};
      "I": {dec_len, dec_pat} = {3'd2, 5'b00000};
      "J": {dec_len, dec_pat} = {3'd4, 5'b01110};
      "K": {dec_len, dec_pat} = {3'd3, 5'b10100};
      "L": {dec_len, dec_pat} = {3'd4, 5'b01000};
      "M": {dec_len, dec_pat} = {3'd2, 5'b11000};
      "N": {dec_len, dec_pat} = {3'd2, 5'b10000};
      "O": {dec_len, dec_pat} = {3'd3, 5'b11100};
      "P": {dec_len, dec_pat} = {3'd4, 5'b01100};
      "Q": {dec_len, dec_pat} = {3'd4, 5'b11010};
      "R": {dec_len, dec_pat} = {3'd3, 5'b01000};
      "S": {dec_len, dec_pat} = {3'd3, 5'b00000};
      "T": {dec_len, dec_pat} = {3'd1, 5'b10000};
      "U": {dec_len, dec_pat} = {3'd3, 5'b00100};
      "V": {dec_len, dec_pat} = {3'd4, 5'b00010};
      "W": {dec_len, dec_pat} = {3'd3, 5'b01100};
      "X": {dec_len, dec_pat} = {3'd4, 5'b10010};
      "Y": {dec_len, dec_pat} = {3'd4, 5'b10110};
      "Z": {dec_len, dec_pat} = {3'd4, 5'b11000};
      "0": {dec_len, dec_pat} = {3'd5, 5'b11111};
      "1": {dec_len, dec_pat} = {3'd5, 5'b01111};
      "2": {dec_len, dec_pat} = {3'd5, 5'b00111};
      "3": {dec_len, dec_pat} = {3'd5, 5'b00011};
      "4": {dec_len, dec_pat} = {3'd5, 5'b00001};
      "5": {dec_len, dec_pat} = {3'd5, 5'b00000};
      "6": {dec_len, dec_pat} = {3'd5, 5'b10000};
      "7": {dec_len, dec_pat} = {3'd5, 5'b11000};
      "8": {dec_len, dec_pat} = {3'd5, 5'b11100};
      "9": {dec_len, dec_pat} = {3'd5, 5'b11110};
      " ": dec_space = 1'b1;
      default: dec_ok = 1'b0;
    endcase
  end

  assign transfer = char_valid_i && (state_q == S_IDLE);
  assign done     = (presc_q == '0) && (unit_q == 2'd0);

  // Next-state, unit timing and element sequencing.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    unit_d     = unit_q;
    idx_d      = idx_q;
    len_d      = len_q;
    pat_d      = pat_q;
    err_d      = 1'b0;
    load       = 1'b0;
    load_units = 3'd1;

    if (state_q != S_IDLE) begin
      if (presc_q == '0) begin
        presc_d = DIV_MAX;
        unit_d  = unit_q - 2'd1;
      end else begin
        presc_d = presc_q - DIV_WIDTH'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (transfer) begin
          if (dec_space) begin
            state_d    = S_WORD_GAP;
            load       = 1'b1;
            load_units = 3'd4;
          end else if (dec_ok) begin
            state_d    = S_MARK;
            pat_d      = dec_pat;
            len_d      = dec_len;
            idx_d      = 3'd0;
            load       = 1'b1;
            load_units = dec_pat[4] ? 3'd3 : 3'd1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_MARK: begin
        if (done) begin
          load = 1'b1;
          if (idx_q == (len_q - 3'd1)) begin
            state_d    = S_CHAR_GAP;
            load_units = 3'd3;
          end else begin
            state_d    = S_ELEM_GAP;
            idx_d      = idx_q + 3'd1;
            load_units = 3'd1;
          end
        end
      end
      S_ELEM_GAP: begin
        if (done) begin
          state_d    = S_MARK;
          load       = 1'b1;
          load_units = pat_q[3'd4 - idx_q] ? 3'd3 : 3'd1;
        end
      end
      S_CHAR_GAP: begin
        if (done) begin
          state_d = S_IDLE;
          idx_d   = 3'd0;
          load    = 1'b1;
        end
      end
      S_WORD_GAP: begin
        if (done) begin
          state_d = S_IDLE;
          load    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        load    = 1'b1;
      end
    endcase

    // Entering a state (IDLE included) restarts its unit timer from the top.
    if (load) begin
      presc_d = DIV_MAX;
      unit_d  = 2'(load_units - 3'd1);
    end

    key_d = (state_d == S_MARK);
  end

  // State and datapath registers; reset aborts any character immediately.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      presc_q <= DIV_MAX;
      unit_q  <= 2'd0;
      idx_q   <= 3'd0;
      len_q   <= 3'd0;
      pat_q   <= 5'b00000;
      key_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      unit_q  <= unit_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      key_q   <= key_d;
      err_q   <= err_d;
    end
  end

  assign char_ready_o = (state_q == S_IDLE);
  assign busy_o       = ~char_ready_o;
  assign key_o        = key_q;
  assign error_o      = err_q;

endmodule
